// File: rtl/dm_access_ctrl.sv
// Data-memory access controller: turns a MEM-stage load/store into a single
// bus transaction with alignment checking, lane steering, load extension and bus timeout.
module dm_access_ctrl #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic [3:0]  op,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic        done,
   output logic [31:0] rdata,
   output logic [1:0]  exc,
   output logic        bus_req,
   output logic        bus_we,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   // state | meaning
   // IDLE  | waiting for a valid request; aligned -> BUS, misaligned -> RESP
   // BUS   | bus_req held, waiting for bus_ack or timeout
   // RESP  | one-cycle done strobe with rdata/exc, then back to IDLE
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUS  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam logic [3:0] OP_LW  = 4'd1;
   localparam logic [3:0] OP_LH  = 4'd2;
   localparam logic [3:0] OP_LHU = 4'd3;
   localparam logic [3:0] OP_LB  = 4'd4;
   localparam logic [3:0] OP_LBU = 4'd5;
   localparam logic [3:0] OP_SW  = 4'd6;
   localparam logic [3:0] OP_SH  = 4'd7;
   localparam logic [3:0] OP_SB  = 4'd8;

   localparam logic [1:0] EXC_OK    = 2'd0;
   localparam logic [1:0] EXC_LMIS  = 2'd1;
   localparam logic [1:0] EXC_SMIS  = 2'd2;
   localparam logic [1:0] EXC_TMOUT = 2'd3;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t      state;
   logic [7:0]  cnt;
   logic [3:0]  lat_op;
   logic [1:0]  lat_off;

   logic        op_valid;
   logic        is_store;
   logic        is_word;
   logic        is_half;
   logic        aligned;
   logic [3:0]  next_be;
   logic [31:0] next_wdata;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_data;

   always_comb begin
      op_valid = (op >= OP_LW) && (op <= OP_SB);
      is_store = (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
      is_word  = (op == OP_LW) || (op == OP_SW);
      is_half  = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);

      if (is_word)
         aligned = (addr[1:0] == 2'b00);
      else if (is_half)
         aligned = (addr[0] == 1'b0);
      else
         aligned = 1'b1;

      if (is_word) begin
         next_be    = 4'b1111;
         next_wdata = wdata;
      end else if (is_half) begin
         next_be    = addr[1] ? 4'b1100 : 4'b0011;
         next_wdata = {2{wdata[15:0]}};
      end else begin
         case (addr[1:0])
            2'd0:    next_be = 4'b0001;
            2'd1:    next_be = 4'b0010;
            2'd2:    next_be = 4'b0100;
            default: next_be = 4'b1000;
         endcase
         next_wdata = {4{wdata[7:0]}};
      end
   end

   assign stall = req && op_valid && (state != S_RESP);

   // lane extraction uses the latched op/offset, not the live pipeline inputs
   always_comb begin
      case (lat_off)
         2'd0:    byte_sel = bus_rdata[7:0];
         2'd1:    byte_sel = bus_rdata[15:8];
         2'd2:    byte_sel = bus_rdata[23:16];
         default: byte_sel = bus_rdata[31:24];
      endcase
      half_sel = lat_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];

      case (lat_op)
         OP_LW:   load_data = bus_rdata;
         OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
         OP_LHU:  load_data = {16'h0000, half_sel};
         OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
         OP_LBU:  load_data = {24'h000000, byte_sel};
         default: load_data = 32'h0000_0000;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         cnt       <= 8'd0;
         lat_op    <= 4'd0;
         lat_off   <= 2'd0;
         done      <= 1'b0;
         rdata     <= 32'h0000_0000;
         exc       <= EXC_OK;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_be    <= 4'b0000;
         bus_addr  <= 32'h0000_0000;
         bus_wdata <= 32'h0000_0000;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req && op_valid) begin
                  if (aligned) begin
                     state     <= S_BUS;
                     cnt       <= 8'd0;
                     lat_op    <= op;
                     lat_off   <= addr[1:0];
                     bus_req   <= 1'b1;
                     bus_we    <= is_store;
                     bus_be    <= next_be;
                     bus_addr  <= {addr[31:2], 2'b00};
                     bus_wdata <= next_wdata;
                  end else begin
                     state <= S_RESP;
                     done  <= 1'b1;
                     rdata <= 32'h0000_0000;
                     exc   <= is_store ? EXC_SMIS : EXC_LMIS;
                  end
               end
            end
            S_BUS: begin
               if (bus_ack) begin
                  state   <= S_RESP;
                  bus_req <= 1'b0;
                  done    <= 1'b1;
                  rdata   <= load_data;
                  exc     <= EXC_OK;
               end else if (cnt == CNT_LAST) begin
                  state   <= S_RESP;
                  bus_req <= 1'b0;
                  done    <= 1'b1;
                  rdata   <= 32'h0000_0000;
                  exc     <= EXC_TMOUT;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            S_RESP: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
